// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - shared types and op decode for the stack controller
//   stack_op_e    : decoded request operation (PUSH/POP/PEEK)
//   stack_err_e   : response status code carried on rsp_err
//   stack_state_e : sequencer states
package stack_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_PEEK = 2'd2
  } stack_op_e;

  typedef enum logic [1:0] {
    ERR_OK        = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2,
    ERR_TIMEOUT   = 2'd3
  } stack_err_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEC   = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } stack_state_e;

  // The reserved encoding 3 behaves as PEEK.
  function automatic stack_op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'd0:    return OP_PUSH;
      2'd1:    return OP_POP;
      default: return OP_PEEK;
    endcase
  endfunction

endpackage

// File: rtl/stack_ctrl_timeout.sv
// rtl/stack_ctrl_timeout.sv - saturating wait counter bounding memory accesses
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : hold the count at zero
//   en_i      : count one more cycle without acknowledge
//   expired_o : the current cycle is the last one allowed before timing out
module stack_ctrl_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != CW'(TIMEOUT))) begin
      count_q <= count_q + CW'(1);
    end
  end

  // count_q holds the number of unacknowledged cycles already spent, so the
  // wait ends after exactly TIMEOUT cycles when this cycle also goes unacked.
  assign expired_o = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - PUSH/POP/PEEK sequencer for a downward-growing stack
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready/req_op/req_data : request from the CPU control unit
//   rsp_valid/rsp_data/rsp_err    : one-cycle response pulse and status
//   sp_value                      : current SP from the SP register
//   sp_oe_a/sp_pre_dec/sp_post_inc : SP register strobes
//   mem_rd/mem_wr/mem_wdata/mem_rdata/mem_ack : memory port
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned     WORD        = 32,
  parameter logic [WORD-1:0] STACK_BASE  = 32'h0000_1000,
  parameter logic [WORD-1:0] STACK_LIMIT = 32'h0000_0800,
  parameter int unsigned     TIMEOUT     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [WORD-1:0] req_data,
  output logic            rsp_valid,
  output logic [WORD-1:0] rsp_data,
  output logic [1:0]      rsp_err,
  input  logic [WORD-1:0] sp_value,
  output logic            sp_oe_a,
  output logic            sp_pre_dec,
  output logic            sp_post_inc,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            mem_ack
);

  stack_state_e    state_q;
  stack_op_e       op_q;
  logic [WORD-1:0] data_q;

  logic            rsp_valid_q;
  stack_err_e      rsp_err_q;
  logic [WORD-1:0] rsp_data_q;
  logic            sp_oe_a_q;
  logic            sp_pre_dec_q;
  logic            sp_post_inc_q;
  logic            mem_rd_q;
  logic            mem_wr_q;
  logic [WORD-1:0] mem_wdata_q;

  stack_op_e req_op_dec;
  logic      waiting;
  logic      tmo_expired;

  assign req_op_dec = decode_op(req_op);
  assign waiting    = (state_q == ST_WRITE) || (state_q == ST_READ);

  // Held clear outside WRITE/READ, so every wait starts from zero.
  stack_ctrl_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!waiting),
    .en_i      (waiting && !mem_ack),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_PUSH;
      data_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= ERR_OK;
      rsp_data_q    <= '0;
      sp_oe_a_q     <= 1'b0;
      sp_pre_dec_q  <= 1'b0;
      sp_post_inc_q <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      // Pulse-type outputs default low; each lives for a single cycle.
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= ERR_OK;
      rsp_data_q    <= '0;
      sp_pre_dec_q  <= 1'b0;
      sp_post_inc_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op_dec;
            data_q <= req_data;
            if (req_op_dec == OP_PUSH) begin
              if (sp_value == STACK_LIMIT) begin
                state_q     <= ST_RESP;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= ERR_OVERFLOW;
              end else begin
                state_q      <= ST_DEC;
                sp_pre_dec_q <= 1'b1;
              end
            end else if (sp_value == STACK_BASE) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= ERR_UNDERFLOW;
            end else begin
              state_q   <= ST_READ;
              sp_oe_a_q <= 1'b1;
              mem_rd_q  <= 1'b1;
            end
          end
        end

        ST_DEC: begin
          state_q     <= ST_WRITE;
          sp_oe_a_q   <= 1'b1;
          mem_wr_q    <= 1'b1;
          mem_wdata_q <= data_q;
        end

        ST_WRITE: begin
          // An ack on the last allowed cycle still completes the write.
          if (mem_ack || tmo_expired) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= mem_ack ? ERR_OK : ERR_TIMEOUT;
            sp_oe_a_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
          end
        end

        ST_READ: begin
          if (mem_ack || tmo_expired) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            sp_oe_a_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            if (mem_ack) begin
              rsp_data_q <= mem_rdata;
              // Raised at the ack edge so it never overlaps sp_oe_a; SP moves
              // at the end of the response cycle, after the address is used.
              sp_post_inc_q <= (op_q == OP_POP);
            end else begin
              rsp_err_q <= ERR_TIMEOUT;
            end
          end
        end

        ST_RESP: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_data    = rsp_data_q;
  assign sp_oe_a     = sp_oe_a_q;
  assign sp_pre_dec  = sp_pre_dec_q;
  assign sp_post_inc = sp_post_inc_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - self-checking bench for stack_ctrl
module tb_stack_ctrl;

  localparam int unsigned WORD  = 32;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] LIMIT = 32'h0000_0800;
  localparam int          TMO   = 16;
  localparam int          NEVER = 1000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic [31:0] sp_value;
  logic        sp_oe_a;
  logic        sp_pre_dec;
  logic        sp_post_inc;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  // Memory as the DUT sees it, and the model's own view of the stack.
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  typedef struct {
    logic [1:0]  err;
    logic [31:0] data;
    int          lat;
    logic [31:0] sp;
    int          wr;
    int          rd;
    int          dec;
    int          inc;
  } res_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] sp;
    logic [31:0] data;
    logic [31:0] rdata;
    int          lat;
    res_t        exp;
  } vec_t;

  stack_ctrl #(
    .WORD        (WORD),
    .STACK_BASE  (BASE),
    .STACK_LIMIT (LIMIT),
    .TIMEOUT     (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .sp_value    (sp_value),
    .sp_oe_a     (sp_oe_a),
    .sp_pre_dec  (sp_pre_dec),
    .sp_post_inc (sp_post_inc),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Contents of never-written locations.
  function automatic logic [31:0] fill(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One clock; the bench-side SP register follows the strobes of the cycle.
  task automatic clk_cycle();
    logic dec;
    logic inc;
    dec = sp_pre_dec;
    inc = sp_post_inc;
    @(posedge clk);
    #1;
    if (dec === 1'b1) sp_value = sp_value - 32'd1;
    if (inc === 1'b1) sp_value = sp_value + 32'd1;
    @(negedge clk);
  endtask

  // Expected result from the stack rules: bounds, wait length and SP effect.
  task automatic model(input logic [1:0] op, input logic [31:0] sp, input logic [31:0] data,
                       input int lat, output res_t r);
    bit acked;
    acked  = (lat < TMO);
    r.err  = 2'd0;
    r.data = 32'd0;
    r.lat  = 0;
    r.sp   = sp;
    r.wr   = 0;
    r.rd   = 0;
    r.dec  = 0;
    r.inc  = 0;
    if (op == 2'd0) begin
      if (sp == LIMIT) begin
        r.err = 2'd1;
        r.lat = 1;
      end else begin
        r.dec = 1;
        r.sp  = sp - 32'd1;
        if (acked) begin
          r.wr = lat + 1;
          r.lat = lat + 3;
          ref_mem[sp - 32'd1] = data;
        end else begin
          r.err = 2'd3;
          r.wr  = TMO;
          r.lat = TMO + 2;
        end
      end
    end else if (sp == BASE) begin
      r.err = 2'd2;
      r.lat = 1;
    end else if (acked) begin
      r.rd   = lat + 1;
      r.lat  = lat + 2;
      r.data = ref_mem.exists(sp) ? ref_mem[sp] : fill(sp);
      if (op == 2'd1) begin
        r.inc = 1;
        r.sp  = sp + 32'd1;
      end
    end else begin
      r.err = 2'd3;
      r.rd  = TMO;
      r.lat = TMO + 1;
    end
  endtask

  // Issue one request from IDLE and act as the memory, acking after 'lat' wait cycles.
  task automatic run_txn(input logic [1:0] op, input logic [31:0] data, input int lat,
                         output res_t o, output int bad, output int ready_after);
    int n;
    int waits;
    bit got;
    o.err = 2'd0; o.data = 32'd0; o.lat = 0; o.sp = 32'd0;
    o.wr = 0; o.rd = 0; o.dec = 0; o.inc = 0;
    bad = 0; n = 0; waits = 0; got = 1'b0;
    if (req_ready !== 1'b1) bad++;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    mem_ack   = ($urandom_range(0, 3) == 0);
    mem_rdata = $urandom;
    clk_cycle();
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_data  = $urandom;
    while (!got && n < 200) begin
      n++;
      if (sp_pre_dec === 1'b1) o.dec++;
      if (sp_post_inc === 1'b1) o.inc++;
      if (int'(sp_oe_a) + int'(sp_pre_dec) + int'(sp_post_inc) > 1) bad++;
      if (mem_wr === 1'b1) begin
        o.wr++;
        if (mem_wdata !== data || sp_oe_a !== 1'b1) bad++;
      end
      if (mem_rd === 1'b1) begin
        o.rd++;
        if (sp_oe_a !== 1'b1) bad++;
      end
      if (mem_rd === 1'b1 && mem_wr === 1'b1) bad++;
      if (req_ready !== 1'b0) bad++;
      if (rsp_valid === 1'b1) begin
        got   = 1'b1;
        o.err = rsp_err;
        o.data = rsp_data;
        o.lat = n;
      end
      if (mem_wr === 1'b1 || mem_rd === 1'b1) begin
        if (waits == lat) begin
          mem_ack = 1'b1;
          if (mem_rd === 1'b1) mem_rdata = mem.exists(sp_value) ? mem[sp_value] : fill(sp_value);
          else mem[sp_value] = mem_wdata;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
        waits++;
      end else begin
        // Stray acks outside an access must be ignored.
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
      clk_cycle();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles, required one", n);
    end
    o.sp = sp_value;
    ready_after = (req_ready === 1'b1 && rsp_valid === 1'b0) ? 1 : 0;
  endtask

  task automatic compare(input string tag, input res_t e, input res_t o, input int bad,
                         input int ready_after);
    chk($sformatf("%s.err", tag), 32'(o.err), 32'(e.err));
    chk($sformatf("%s.data", tag), o.data, e.data);
    chk($sformatf("%s.latency", tag), 32'(o.lat), 32'(e.lat));
    chk($sformatf("%s.sp", tag), o.sp, e.sp);
    chk($sformatf("%s.wr_cycles", tag), 32'(o.wr), 32'(e.wr));
    chk($sformatf("%s.rd_cycles", tag), 32'(o.rd), 32'(e.rd));
    chk($sformatf("%s.pre_dec", tag), 32'(o.dec), 32'(e.dec));
    chk($sformatf("%s.post_inc", tag), 32'(o.inc), 32'(e.inc));
    chk($sformatf("%s.protocol", tag), 32'(bad), 32'd0);
    chk($sformatf("%s.ready_after", tag), 32'(ready_after), 32'd1);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] sp, input logic [31:0] data,
                              input logic [31:0] rdata, input int lat, input logic [1:0] err,
                              input logic [31:0] edata, input int elat, input logic [31:0] esp,
                              input int wr, input int rd, input int dec, input int inc);
    vec_t v;
    v.op = op; v.sp = sp; v.data = data; v.rdata = rdata; v.lat = lat;
    v.exp.err = err; v.exp.data = edata; v.exp.lat = elat; v.exp.sp = esp;
    v.exp.wr = wr; v.exp.rd = rd; v.exp.dec = dec; v.exp.inc = inc;
    return v;
  endfunction

  initial begin
    vec_t        vecs[12];
    res_t        o;
    res_t        e;
    int          bad;
    int          rdy;
    int          quiet;
    int          lat;
    int          r;
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] msp;

    //            op    sp            data          rdata         lat    err   edata         elat esp           wr  rd  dec inc
    vecs[0]  = mk(2'd0, 32'h0000_1000, 32'hDEADBEEF, 32'h0,        2,     2'd0, 32'h0,        5,  32'h0000_0FFF, 3,  0,  1,  0);
    vecs[1]  = mk(2'd1, 32'h0000_0FFF, 32'h0,        32'hDEADBEEF, 0,     2'd0, 32'hDEADBEEF, 2,  32'h0000_1000, 0,  1,  0,  1);
    vecs[2]  = mk(2'd2, 32'h0000_0FFF, 32'h0,        32'hDEADBEEF, 0,     2'd0, 32'hDEADBEEF, 2,  32'h0000_0FFF, 0,  1,  0,  0);
    vecs[3]  = mk(2'd1, 32'h0000_1000, 32'h0,        32'h0,        0,     2'd2, 32'h0,        1,  32'h0000_1000, 0,  0,  0,  0);
    vecs[4]  = mk(2'd2, 32'h0000_1000, 32'h0,        32'h0,        0,     2'd2, 32'h0,        1,  32'h0000_1000, 0,  0,  0,  0);
    vecs[5]  = mk(2'd3, 32'h0000_1000, 32'h0,        32'h0,        0,     2'd2, 32'h0,        1,  32'h0000_1000, 0,  0,  0,  0);
    vecs[6]  = mk(2'd0, 32'h0000_0800, 32'h11112222, 32'h0,        0,     2'd1, 32'h0,        1,  32'h0000_0800, 0,  0,  0,  0);
    vecs[7]  = mk(2'd0, 32'h0000_0900, 32'hCAFEF00D, 32'h0,        NEVER, 2'd3, 32'h0,        18, 32'h0000_08FF, 16, 0,  1,  0);
    vecs[8]  = mk(2'd1, 32'h0000_0900, 32'h0,        32'h55AA55AA, NEVER, 2'd3, 32'h0,        17, 32'h0000_0900, 0,  16, 0,  0);
    vecs[9]  = mk(2'd0, 32'h0000_0801, 32'h0BADC0DE, 32'h0,        15,    2'd0, 32'h0,        18, 32'h0000_0800, 16, 0,  1,  0);
    vecs[10] = mk(2'd3, 32'h0000_0FFF, 32'h0,        32'h13579BDF, 1,     2'd0, 32'h13579BDF, 3,  32'h0000_0FFF, 0,  2,  0,  0);
    vecs[11] = mk(2'd1, 32'h0000_0801, 32'h0,        32'h2468ACE0, 15,    2'd0, 32'h2468ACE0, 17, 32'h0000_0802, 0,  16, 0,  1);

    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_data = 32'd0;
    sp_value = BASE; mem_rdata = 32'd0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    chk("reset.rsp_data", rsp_data, 32'd0);
    chk("reset.strobes", 32'({sp_oe_a, sp_pre_dec, sp_post_inc, mem_rd, mem_wr}), 32'd0);
    chk("reset.mem_wdata", mem_wdata, 32'd0);

    for (int i = 0; i < 12; i++) begin
      sp_value = vecs[i].sp;
      mem[vecs[i].sp] = vecs[i].rdata;
      run_txn(vecs[i].op, vecs[i].data, vecs[i].lat, o, bad, rdy);
      compare($sformatf("vec%0d", i), vecs[i].exp, o, bad, rdy);
    end

    // Reset in the middle of a POP read that never gets acked.
    sp_value = 32'h0000_0FFF;
    mem_ack = 1'b0;
    req_valid = 1'b1; req_op = 2'd1; req_data = 32'd0;
    clk_cycle();
    req_valid = 1'b0;
    clk_cycle();
    clk_cycle();
    chk("rstrd.mem_rd_before", 32'(mem_rd), 32'd1);
    rst = 1'b1;
    clk_cycle();
    rst = 1'b0;
    chk("rstrd.mem_rd", 32'(mem_rd), 32'd0);
    chk("rstrd.sp_oe_a", 32'(sp_oe_a), 32'd0);
    chk("rstrd.req_ready", 32'(req_ready), 32'd1);
    quiet = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) quiet++;
      clk_cycle();
    end
    chk("rstrd.no_activity", 32'(quiet), 32'd0);
    chk("rstrd.sp_kept", sp_value, 32'h0000_0FFF);
    run_txn(2'd0, 32'h12345678, 1, o, bad, rdy);
    e.err = 2'd0; e.data = 32'd0; e.lat = 4; e.sp = 32'h0000_0FFE;
    e.wr = 2; e.rd = 0; e.dec = 1; e.inc = 0;
    compare("rstrd.push", e, o, bad, rdy);

    // Randomized traffic: first from an empty stack, then near the full bound.
    for (int phase = 0; phase < 2; phase++) begin
      mem.delete();
      ref_mem.delete();
      msp = (phase == 0) ? BASE : LIMIT + 32'd3;
      sp_value = msp;
      for (int t = 0; t < 150; t++) begin
        r    = int'($urandom_range(0, 9));
        op   = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        data = $urandom;
        lat  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 5));
        model(op, msp, data, lat, e);
        msp = e.sp;
        run_txn(op, data, lat, o, bad, rdy);
        compare($sformatf("rnd%0d_%0d", phase, t), e, o, bad, rdy);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
